// File: rtl/srm_mem_ctrl_if.sv
// CPU-side memory bus of the Simple RISC Machine.
// The CPU drives command/address/data (master); the memory controller
// returns registered read data and a one-cycle completion pulse (slave).
interface srm_mem_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
);
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              mem_ready;

   modport master (
      output mem_cmd,
      output mem_addr,
      output write_data,
      input  read_data,
      input  mem_ready
   );

   modport slave (
      input  mem_cmd,
      input  mem_addr,
      input  write_data,
      output read_data,
      output mem_ready
   );
endinterface

// File: rtl/srm_mem_ctrl.sv
// Memory controller between the SRM cpu and its program/data RAM.
// Accepts one CPU command at a time in IDLE, applies RD_LAT cycles of read
// latency, and signals completion with a one-cycle mem_ready pulse. A side-band
// loader port writes RAM while the CPU bus is idle.
// Compile-time option: define SRM_MMIO_EN to map the board switches (SW_ADDR,
// read-only) and LEDs (LED_ADDR) into the address space. Without it, led stays
// 0 and both addresses are plain (normally out-of-range) addresses.
// reset is asynchronous and active-low; RAM contents survive reset.
module srm_mem_ctrl #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 9,
   parameter int                DEPTH    = 256,
   parameter int                RD_LAT   = 1,
   parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
   parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
   input  logic              clk,
   input  logic              reset,
   srm_mem_ctrl_if.slave     bus,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ack,
   input  logic [7:0]        sw,
   output logic [7:0]        led,
   output logic              addr_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = 2;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

`ifdef SRM_MMIO_EN
   localparam bit MMIO_ON = 1'b1;
`else
   localparam bit MMIO_ON = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      ACK     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              mem_ready_q, mem_ready_d;
   logic              load_ack_q, load_ack_d;
   logic [7:0]        led_q, led_d;
   logic              addr_err_q, addr_err_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              ram_we;
   logic [IDX_W-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_word;
   logic              data_edge;
   logic [DATA_W-1:0] sw_word;
   logic [DATA_W-1:0] led_word;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   function automatic logic is_sw(input logic [ADDR_W-1:0] a);
      return MMIO_ON && (a == SW_ADDR);
   endfunction

   function automatic logic is_led(input logic [ADDR_W-1:0] a);
      return MMIO_ON && (a == LED_ADDR);
   endfunction

   function automatic logic [IDX_W-1:0] ram_idx(input logic [ADDR_W-1:0] a);
      return a[IDX_W-1:0];
   endfunction

   assign sw_word  = {{(DATA_W-8){1'b0}}, sw};
   assign led_word = {{(DATA_W-8){1'b0}}, led_q};

   // Read-side lookup: RD_LAT==1 samples straight off the bus in IDLE, longer latencies use the latched address.
   always_comb begin
      rd_addr = (state_q == IDLE) ? bus.mem_addr : addr_q;
      rd_word = '0;
      if (is_sw(rd_addr)) begin
         rd_word = sw_word;
      end else if (is_led(rd_addr)) begin
         rd_word = led_word;
      end else if (in_range(rd_addr)) begin
         rd_word = mem[ram_idx(rd_addr)];
      end
   end

   // Next-state, latency counter, RAM/LED write decode and registered output updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      read_data_d = read_data_q;
      mem_ready_d = 1'b0;
      load_ack_d  = 1'b0;
      led_d       = led_q;
      addr_err_d  = addr_err_q;
      ram_we      = 1'b0;
      ram_waddr   = '0;
      ram_wdata   = '0;
      data_edge   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mem_cmd == CMD_READ) begin
               addr_d = bus.mem_addr;
               if (!in_range(bus.mem_addr) && !is_sw(bus.mem_addr) && !is_led(bus.mem_addr)) begin
                  addr_err_d = 1'b1;
               end
               if (RD_LAT == 1) begin
                  state_d     = ACK;
                  mem_ready_d = 1'b1;
                  data_edge   = 1'b1;
               end else begin
                  state_d = RD_WAIT;
                  cnt_d   = CNT_W'(RD_LAT - 2);
               end
            end else if (bus.mem_cmd == CMD_WRITE) begin
               addr_d      = bus.mem_addr;
               state_d     = ACK;
               mem_ready_d = 1'b1;
               if (is_led(bus.mem_addr)) begin
                  led_d = bus.write_data[7:0];
               end else if (is_sw(bus.mem_addr)) begin
                  led_d = led_q;
               end else if (in_range(bus.mem_addr)) begin
                  ram_we    = 1'b1;
                  ram_waddr = ram_idx(bus.mem_addr);
                  ram_wdata = bus.write_data;
               end else begin
                  addr_err_d = 1'b1;
               end
            end else if (load_en && !load_ack_q) begin
               // The loader holds load_en through its ack cycle, so it is not re-accepted then.
               load_ack_d = 1'b1;
               if (in_range(load_addr)) begin
                  ram_we    = 1'b1;
                  ram_waddr = ram_idx(load_addr);
                  ram_wdata = load_data;
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d     = ACK;
               mem_ready_d = 1'b1;
               data_edge   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (data_edge) begin
         read_data_d = rd_word;
      end

      if (!reset) begin
         ram_we = 1'b0;
      end
   end

   // Control and output registers; reset aborts any in-flight transaction silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         read_data_q <= '0;
         mem_ready_q <= 1'b0;
         load_ack_q  <= 1'b0;
         led_q       <= '0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         read_data_q <= read_data_d;
         mem_ready_q <= mem_ready_d;
         load_ack_q  <= load_ack_d;
         led_q       <= led_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // RAM storage, deliberately without reset so programs survive a CPU reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
   end

   assign bus.read_data = read_data_q;
   assign bus.mem_ready = mem_ready_q;
   assign load_ack      = load_ack_q;
   assign led           = MMIO_ON ? led_q : 8'h00;
   assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_srm_mem_ctrl.sv
// Directed testbench for srm_mem_ctrl. Three controllers with RD_LAT = 1, 3
// and 4 share clock and reset; index 0/1/2 selects which one a task drives.
module tb_srm_mem_ctrl;

`ifdef SRM_MMIO_EN
   localparam bit MMIO = 1'b1;
`else
   localparam bit MMIO = 1'b0;
`endif

   localparam logic [1:0] NONE  = 2'b00;
   localparam logic [1:0] READ  = 2'b01;
   localparam logic [1:0] WRITE = 2'b10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]        sw;
   logic [2:0][1:0]   cmd;
   logic [2:0][8:0]   addr;
   logic [2:0][15:0]  wdata;
   logic [2:0][15:0]  rdata;
   logic [2:0]        ready;
   logic [2:0]        load_en;
   logic [2:0][8:0]   load_addr;
   logic [2:0][15:0]  load_data;
   logic [2:0]        load_ack;
   logic [2:0][7:0]   led;
   logic [2:0]        addr_err;

   int checks = 0;
   int fails  = 0;

   srm_mem_ctrl_if #(.DATA_W(16), .ADDR_W(9)) if_l1 ();
   srm_mem_ctrl_if #(.DATA_W(16), .ADDR_W(9)) if_l3 ();
   srm_mem_ctrl_if #(.DATA_W(16), .ADDR_W(9)) if_l4 ();

   assign if_l1.mem_cmd    = cmd[0];
   assign if_l1.mem_addr   = addr[0];
   assign if_l1.write_data = wdata[0];
   assign rdata[0]         = if_l1.read_data;
   assign ready[0]         = if_l1.mem_ready;
   assign if_l3.mem_cmd    = cmd[1];
   assign if_l3.mem_addr   = addr[1];
   assign if_l3.write_data = wdata[1];
   assign rdata[1]         = if_l3.read_data;
   assign ready[1]         = if_l3.mem_ready;
   assign if_l4.mem_cmd    = cmd[2];
   assign if_l4.mem_addr   = addr[2];
   assign if_l4.write_data = wdata[2];
   assign rdata[2]         = if_l4.read_data;
   assign ready[2]         = if_l4.mem_ready;

   srm_mem_ctrl #(.RD_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .bus(if_l1),
      .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]),
      .load_ack(load_ack[0]), .sw(sw), .led(led[0]), .addr_err(addr_err[0])
   );

   srm_mem_ctrl #(.RD_LAT(3)) u_lat3 (
      .clk(clk), .reset(reset), .bus(if_l3),
      .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]),
      .load_ack(load_ack[1]), .sw(sw), .led(led[1]), .addr_err(addr_err[1])
   );

   srm_mem_ctrl #(.RD_LAT(4)) u_lat4 (
      .clk(clk), .reset(reset), .bus(if_l4),
      .load_en(load_en[2]), .load_addr(load_addr[2]), .load_data(load_data[2]),
      .load_ack(load_ack[2]), .sw(sw), .led(led[2]), .addr_err(addr_err[2])
   );

   // Issue one CPU command and return the read data and the number of cycles until mem_ready (-1 on timeout).
   task automatic do_op(input int i, input logic [1:0] c, input logic [8:0] a,
                        input logic [15:0] d, output logic [15:0] rd, output int lat);
      @(negedge clk);
      cmd[i] = c; addr[i] = a; wdata[i] = d;
      lat = -1; rd = 16'h0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         cmd[i] = NONE;
         if (ready[i]) begin
            lat = k; rd = rdata[i];
            break;
         end
      end
   endtask

   // Hold a loader request until acked and return the cycles to the ack (-1 on timeout).
   task automatic do_load(input int i, input logic [8:0] a, input logic [15:0] d, output int lat);
      @(negedge clk);
      load_en[i] = 1'b1; load_addr[i] = a; load_data[i] = d;
      lat = -1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (load_ack[i]) begin
            lat = k;
            break;
         end
      end
      load_en[i] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rdata[i] !== 16'h0) begin fails++; $display("[TB] FAIL reset_rdata[%0d] got %h want 0000", i, rdata[i]); end
         checks++;
         if (ready[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready[%0d] got %b want 0", i, ready[i]); end
         checks++;
         if (load_ack[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_load_ack[%0d] got %b want 0", i, load_ack[i]); end
         checks++;
         if (led[i] !== 8'h0) begin fails++; $display("[TB] FAIL reset_led[%0d] got %h want 00", i, led[i]); end
         checks++;
         if (addr_err[i] !== 1'b0) begin fails++; $display("[TB] FAIL reset_addr_err[%0d] got %b want 0", i, addr_err[i]); end
      end
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_read();
      int lat;
      logic [15:0] rd;
      logic seen;
      do_load(1, 9'h005, 16'hBEEF, lat);
      do_op(1, READ, 9'h005, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hBEEF || lat != 3) begin fails++; $display("[TB] FAIL pre_reset_read got %h/%0d want beef/3", rd, lat); end
      @(negedge clk);
      cmd[1] = READ; addr[1] = 9'h005;
      @(negedge clk);
      cmd[1] = NONE;
      reset = 1'b0;
      #1;
      checks++;
      if (rdata[1] !== 16'h0) begin fails++; $display("[TB] FAIL midread_rdata got %h want 0000", rdata[1]); end
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 1) reset = 1'b1;
         if (ready[1]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin fails++; $display("[TB] FAIL midread_ready_pulse got %b want 0", seen); end
      do_op(1, READ, 9'h005, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hBEEF) begin fails++; $display("[TB] FAIL retained_mem got %h want beef", rd); end
      checks++;
      if (lat != 3) begin fails++; $display("[TB] FAIL post_reset_latency got %0d want 3", lat); end
   endtask

   task automatic test_loader_latency();
      int lat;
      int idx[2];
      int exp_lat[2];
      logic [15:0] rd;
      idx[0] = 0; exp_lat[0] = 1;
      idx[1] = 2; exp_lat[1] = 4;
      for (int n = 0; n < 2; n++) begin
         do_load(idx[n], 9'h000, 16'hD007, lat);
         checks++;
         if (lat != 1) begin fails++; $display("[TB] FAIL load0_ack[%0d] got %0d want 1", idx[n], lat); end
         do_load(idx[n], 9'h001, 16'hD102, lat);
         checks++;
         if (lat != 1) begin fails++; $display("[TB] FAIL load1_ack[%0d] got %0d want 1", idx[n], lat); end
         do_op(idx[n], READ, 9'h000, 16'h0, rd, lat);
         checks++;
         if (rd !== 16'hD007) begin fails++; $display("[TB] FAIL read0_data[%0d] got %h want d007", idx[n], rd); end
         checks++;
         if (lat != exp_lat[n]) begin fails++; $display("[TB] FAIL read0_lat[%0d] got %0d want %0d", idx[n], lat, exp_lat[n]); end
         do_op(idx[n], READ, 9'h001, 16'h0, rd, lat);
         checks++;
         if (rd !== 16'hD102) begin fails++; $display("[TB] FAIL read1_data[%0d] got %h want d102", idx[n], rd); end
         checks++;
         if (lat != exp_lat[n]) begin fails++; $display("[TB] FAIL read1_lat[%0d] got %0d want %0d", idx[n], lat, exp_lat[n]); end
      end
   endtask

   task automatic test_write_readback();
      int lat;
      logic [15:0] rd;
      do_op(1, WRITE, 9'h0A3, 16'h0009, rd, lat);
      checks++;
      if (lat != 1) begin fails++; $display("[TB] FAIL write_lat got %0d want 1", lat); end
      checks++;
      if (rdata[1] !== 16'hBEEF) begin fails++; $display("[TB] FAIL write_keeps_rdata got %h want beef", rdata[1]); end
      do_op(1, READ, 9'h0A3, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0009 || lat != 3) begin fails++; $display("[TB] FAIL readback got %h/%0d want 0009/3", rd, lat); end
      // Change the bus to a WRITE while the read is still counting latency.
      @(negedge clk);
      cmd[1] = READ; addr[1] = 9'h0A3;
      @(negedge clk);
      cmd[1] = WRITE; addr[1] = 9'h0A3; wdata[1] = 16'hFFFF;
      @(negedge clk);
      cmd[1] = NONE;
      @(negedge clk);
      checks++;
      if (ready[1] !== 1'b1 || rdata[1] !== 16'h0009) begin
         fails++; $display("[TB] FAIL held_change_read got %b/%h want 1/0009", ready[1], rdata[1]);
      end
      do_op(1, READ, 9'h0A3, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0009) begin fails++; $display("[TB] FAIL ignored_write got %h want 0009", rd); end
   endtask

   task automatic test_collision();
      int lat;
      logic [15:0] rd;
      @(negedge clk);
      cmd[0] = READ; addr[0] = 9'h000;
      load_en[0] = 1'b1; load_addr[0] = 9'h002; load_data[0] = 16'hAAAA;
      @(negedge clk);
      cmd[0] = NONE;
      checks++;
      if (ready[0] !== 1'b1 || rdata[0] !== 16'hD007 || load_ack[0] !== 1'b0) begin
         fails++; $display("[TB] FAIL collision_read got rdy=%b data=%h ack=%b want 1/d007/0", ready[0], rdata[0], load_ack[0]);
      end
      @(negedge clk);
      checks++;
      if (load_ack[0] !== 1'b0) begin fails++; $display("[TB] FAIL collision_ack_early got %b want 0", load_ack[0]); end
      @(negedge clk);
      checks++;
      if (load_ack[0] !== 1'b1) begin fails++; $display("[TB] FAIL collision_ack got %b want 1", load_ack[0]); end
      load_en[0] = 1'b0;
      do_op(0, READ, 9'h002, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hAAAA) begin fails++; $display("[TB] FAIL collision_load_data got %h want aaaa", rd); end
   endtask

   task automatic test_out_of_range();
      int lat;
      logic [15:0] rd;
      checks++;
      if (addr_err[2] !== 1'b0) begin fails++; $display("[TB] FAIL oor_pre_err got %b want 0", addr_err[2]); end
      do_op(2, READ, 9'h1F0, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'h0) begin fails++; $display("[TB] FAIL oor_data got %h want 0000", rd); end
      checks++;
      if (lat != 4) begin fails++; $display("[TB] FAIL oor_lat got %0d want 4", lat); end
      checks++;
      if (addr_err[2] !== 1'b1) begin fails++; $display("[TB] FAIL oor_err got %b want 1", addr_err[2]); end
      do_op(2, READ, 9'h000, 16'h0, rd, lat);
      checks++;
      if (rd !== 16'hD007 || addr_err[2] !== 1'b1) begin
         fails++; $display("[TB] FAIL oor_sticky got %h/%b want d007/1", rd, addr_err[2]);
      end
   endtask

   task automatic test_mmio();
      int lat;
      logic [15:0] rd;
      sw = 8'h5A;
      do_op(0, READ, 9'h140, 16'h0, rd, lat);
      checks++;
      if (rd !== (MMIO ? 16'h005A : 16'h0000)) begin fails++; $display("[TB] FAIL mmio_sw_read got %h", rd); end
      checks++;
      if (lat != 1) begin fails++; $display("[TB] FAIL mmio_read_lat got %0d want 1", lat); end
      do_op(0, WRITE, 9'h100, 16'h12C3, rd, lat);
      @(negedge clk);
      checks++;
      if (led[0] !== (MMIO ? 8'hC3 : 8'h00)) begin fails++; $display("[TB] FAIL mmio_led got %h", led[0]); end
      checks++;
      if (addr_err[0] !== (MMIO ? 1'b0 : 1'b1)) begin fails++; $display("[TB] FAIL mmio_addr_err got %b", addr_err[0]); end
   endtask

   initial begin
      reset = 1'b0;
      sw = 8'h00;
      cmd = '0; addr = '0; wdata = '0;
      load_en = '0; load_addr = '0; load_data = '0;
      $display("[TB] start, MMIO=%0d", MMIO);
      test_reset();
      test_reset_mid_read();
      test_loader_latency();
      test_write_readback();
      test_collision();
      test_out_of_range();
      test_mmio();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
